// File: rtl/game_pkg.sv
// Shared definitions for the sprite game: screen geometry, colour codes,
// sequencer state encoding and a saturating-increment helper.
package game_pkg;

    localparam int SCREEN_W = 160;
    localparam int SCREEN_H = 120;

    localparam logic [7:0] X_MAX = 8'(SCREEN_W - 1);
    localparam logic [7:0] X_END = 8'd154;

    localparam logic [2:0] BG       = 3'b000;
    localparam logic [2:0] OBSTACLE = 3'b010;
    localparam logic [2:0] SPRITE   = 3'b101;

    typedef enum logic [3:0] {
        IDLE,
        INIT,
        DRAW,
        CHECK1,
        CHECK2,
        WAIT_FRAME,
        ERASE,
        MOVE,
        GAME_OVER,
        WIN
    } state_t;

    function automatic logic [7:0] sat_inc8(input logic [7:0] value);
        return (value == 8'hFF) ? value : value + 8'd1;
    endfunction

endpackage

// File: rtl/sprite_motion.sv
// Sprite position and jump motion: x advances per step and saturates at the
// right screen edge; height follows a 1 px/frame rise-to-apex-then-fall arc.
module sprite_motion
    import game_pkg::*;
#(
    parameter logic [7:0] X_START  = 8'd4,
    parameter logic [6:0] Y_GROUND = 7'd100,
    parameter logic [7:0] X_STEP   = 8'd1,
    parameter logic [6:0] JUMP_H   = 7'd20
) (
    input  logic       clock,
    input  logic       resetn,
    input  logic       init,
    input  logic       step,
    input  logic       jump,
    output logic [7:0] x_coord,
    output logic [6:0] y_coord
);

    logic [6:0] height_q;
    logic [6:0] height_d;
    logic       rising_q;
    logic       rising_d;
    logic       jump_pend_q;
    logic       jump_pend_d;
    logic [7:0] x_d;
    logic [6:0] y_d;
    logic [8:0] x_sum;
    logic [6:0] height_up;

    // NOTE: every variable gets its hold value first so no path through the
    // always_comb leaves one unassigned, which would infer a latch.
    always_comb begin
        x_sum       = {1'b0, x_coord} + {1'b0, X_STEP};
        height_up   = height_q + 7'd1;
        x_d         = x_coord;
        height_d    = height_q;
        rising_d    = rising_q;
        jump_pend_d = jump_pend_q;

        if (init) begin
            x_d         = X_START;
            height_d    = '0;
            rising_d    = 1'b0;
            jump_pend_d = 1'b0;
        end else begin
            // A jump is only accepted from standing on the ground.
            if (jump && (height_q == '0) && !rising_q) begin
                jump_pend_d = 1'b1;
            end

            if (step) begin
                x_d = (x_sum > {1'b0, X_MAX}) ? X_MAX : x_sum[7:0];

                if (jump_pend_q) begin
                    height_d    = 7'd1;
                    rising_d    = (JUMP_H > 7'd1);
                    jump_pend_d = 1'b0;
                end else if (rising_q) begin
                    height_d = height_up;
                    if (height_up == JUMP_H) begin
                        rising_d = 1'b0;
                    end
                end else if (height_q != '0) begin
                    height_d = height_q - 7'd1;
                end
            end
        end

        // y is registered alongside height so the output carries no adder.
        y_d = Y_GROUND - height_d;
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            x_coord     <= X_START;
            y_coord     <= Y_GROUND;
            height_q    <= '0;
            rising_q    <= 1'b0;
            jump_pend_q <= 1'b0;
        end else begin
            x_coord     <= x_d;
            y_coord     <= y_d;
            height_q    <= height_d;
            rising_q    <= rising_d;
            jump_pend_q <= jump_pend_d;
        end
    end

endmodule

// File: rtl/game_sequencer.sv
// Per-frame controller: sequences the sprite drawer through erase, move,
// redraw and collision check, and decides game over or win.
module game_sequencer
    import game_pkg::*;
#(
    parameter logic [7:0] X_START  = 8'd4,
    parameter logic [6:0] Y_GROUND = 7'd100,
    parameter logic [7:0] X_STEP   = 8'd1,
    parameter logic [6:0] JUMP_H   = 7'd20
) (
    input  logic       clock,
    input  logic       resetn,
    input  logic       start,
    input  logic       jump,
    input  logic       frame_tick,
    input  logic       draw_done,
    input  logic       collided,
    input  logic       reached_screen_end,
    output logic [7:0] x_coord,
    output logic [6:0] y_coord,
    output logic       draw_req,
    output logic       erase,
    output logic       collision_clear_n,
    output logic       game_over,
    output logic       win,
    output logic [7:0] score
);

    state_t state_q;
    state_t state_d;
    logic   frame_pend_q;
    logic   frame_pend_d;

    sprite_motion #(
        .X_START (X_START),
        .Y_GROUND(Y_GROUND),
        .X_STEP  (X_STEP),
        .JUMP_H  (JUMP_H)
    ) u_motion (
        .clock  (clock),
        .resetn (resetn),
        .init   (state_q == INIT),
        .step   (state_q == MOVE),
        .jump   (jump),
        .x_coord(x_coord),
        .y_coord(y_coord)
    );

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:       if (start)        state_d = INIT;
            INIT:                         state_d = DRAW;
            DRAW:       if (draw_done)    state_d = CHECK1;
            CHECK1:                       state_d = CHECK2;
            CHECK2: begin
                if (collided)                state_d = GAME_OVER;
                else if (reached_screen_end) state_d = WIN;
                else                         state_d = WAIT_FRAME;
            end
            WAIT_FRAME: if (frame_pend_q) state_d = ERASE;
            ERASE:      if (draw_done)    state_d = MOVE;
            MOVE:                         state_d = DRAW;
            GAME_OVER:  if (start)        state_d = IDLE;
            WIN:        if (start)        state_d = IDLE;
            default:                      state_d = IDLE;
        endcase
    end

    // Ticks collapse into one pending frame; the consuming transition in
    // WAIT_FRAME swallows a tick arriving in that same cycle.
    always_comb begin
        frame_pend_d = frame_pend_q;
        if (state_q == INIT) begin
            frame_pend_d = 1'b0;
        end else if ((state_q == WAIT_FRAME) && frame_pend_q) begin
            frame_pend_d = 1'b0;
        end else if (frame_tick) begin
            frame_pend_d = 1'b1;
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q      <= IDLE;
            frame_pend_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            frame_pend_q <= frame_pend_d;
        end
    end

    // Outputs are registered from the next state so they line up with it.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            draw_req          <= 1'b0;
            erase             <= 1'b0;
            collision_clear_n <= 1'b0;
            game_over         <= 1'b0;
            win               <= 1'b0;
            score             <= '0;
        end else begin
            draw_req          <= ((state_d == DRAW)  && (state_q != DRAW)) ||
                                 ((state_d == ERASE) && (state_q != ERASE));
            erase             <= (state_d == ERASE);
            collision_clear_n <= (state_d != IDLE);
            game_over         <= (state_d == GAME_OVER);
            win               <= (state_d == WIN);
            if (state_q == INIT) begin
                score <= '0;
            end else if (state_q == MOVE) begin
                score <= sat_inc8(score);
            end
        end
    end

endmodule

// File: tb/tb_game_sequencer.sv
// Directed bench for game_sequencer with a fixed-latency drawer model.
module tb_game_sequencer;

    localparam int DRAW_CYCLES = 10;

    logic       clock;
    logic       resetn;
    logic       start;
    logic       jump;
    logic       frame_tick;
    logic       draw_done;
    logic       collided;
    logic       reached_screen_end;
    logic [7:0] x_coord;
    logic [6:0] y_coord;
    logic       draw_req;
    logic       erase;
    logic       collision_clear_n;
    logic       game_over;
    logic       win;
    logic [7:0] score;

    int errors = 0;
    int checks = 0;

    int         req_count   = 0;
    int         erase_reqs  = 0;
    int         stable_viol = 0;
    bit         busy        = 0;
    int         cnt         = 0;
    logic [7:0] cap_x;
    logic [6:0] cap_y;
    logic       cap_erase;

    game_sequencer dut (
        .clock             (clock),
        .resetn            (resetn),
        .start             (start),
        .jump              (jump),
        .frame_tick        (frame_tick),
        .draw_done         (draw_done),
        .collided          (collided),
        .reached_screen_end(reached_screen_end),
        .x_coord           (x_coord),
        .y_coord           (y_coord),
        .draw_req          (draw_req),
        .erase             (erase),
        .collision_clear_n (collision_clear_n),
        .game_over         (game_over),
        .win               (win),
        .score             (score)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Drawer model: answers each draw_req with draw_done DRAW_CYCLES later and
    // watches that position and erase stay put during the pass.
    always @(negedge clock) begin
        draw_done = 1'b0;
        if (!resetn) begin
            busy = 0;
        end else begin
            if (busy) begin
                if (x_coord !== cap_x || y_coord !== cap_y || erase !== cap_erase)
                    stable_viol++;
                cnt--;
                if (cnt == 0) begin
                    draw_done = 1'b1;
                    busy = 0;
                end
            end
            if (draw_req === 1'b1) begin
                req_count++;
                if (erase === 1'b1) erase_reqs++;
                busy      = 1;
                cnt       = DRAW_CYCLES;
                cap_x     = x_coord;
                cap_y     = y_coord;
                cap_erase = erase;
            end
        end
    end

    task automatic pulse_start();
        @(negedge clock) start = 1'b1;
        @(negedge clock) start = 1'b0;
    endtask

    task automatic pulse_jump();
        @(negedge clock) jump = 1'b1;
        @(negedge clock) jump = 1'b0;
    endtask

    task automatic pulse_tick();
        @(negedge clock) frame_tick = 1'b1;
        @(negedge clock) frame_tick = 1'b0;
    endtask

    task automatic wait_reqs(input int target);
        int n;
        n = 0;
        while (req_count < target && n < 500) begin
            @(negedge clock);
            n++;
        end
        checks++;
        if (req_count < target) begin
            errors++;
            $display("FAIL wait_draw_req: count=%0d required=%0d", req_count, target);
        end
    endtask

    task automatic settle();
        int n;
        n = 0;
        while (busy && n < 100) begin
            @(negedge clock);
            n++;
        end
        repeat (4) @(negedge clock);
    endtask

    task automatic do_frame();
        int base;
        base = req_count;
        pulse_tick();
        wait_reqs(base + 2);
        settle();
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        start = 0; jump = 0; frame_tick = 0; collided = 0; reached_screen_end = 0;
        repeat (2) @(negedge clock);
        checks += 8;
        if (x_coord !== 8'd4)           begin errors++; $display("FAIL reset_x: got %0d want 4", x_coord); end
        if (y_coord !== 7'd100)         begin errors++; $display("FAIL reset_y: got %0d want 100", y_coord); end
        if (draw_req !== 1'b0)          begin errors++; $display("FAIL reset_draw_req: got %b want 0", draw_req); end
        if (erase !== 1'b0)             begin errors++; $display("FAIL reset_erase: got %b want 0", erase); end
        if (collision_clear_n !== 1'b0) begin errors++; $display("FAIL reset_clear_n: got %b want 0", collision_clear_n); end
        if (game_over !== 1'b0)         begin errors++; $display("FAIL reset_game_over: got %b want 0", game_over); end
        if (win !== 1'b0)               begin errors++; $display("FAIL reset_win: got %b want 0", win); end
        if (score !== 8'd0)             begin errors++; $display("FAIL reset_score: got %0d want 0", score); end
        @(negedge clock) resetn = 1'b1;
        repeat (3) @(negedge clock);
        checks += 2;
        if (collision_clear_n !== 1'b0) begin errors++; $display("FAIL idle_clear_n: got %b want 0", collision_clear_n); end
        if (req_count !== 0)            begin errors++; $display("FAIL idle_no_req: got %0d want 0", req_count); end
    endtask

    task automatic test_normal_frame();
        pulse_start();
        checks++;
        if (collision_clear_n !== 1'b1) begin errors++; $display("FAIL start_clear_n: got %b want 1", collision_clear_n); end
        wait_reqs(1);
        settle();
        checks += 3;
        if (x_coord !== 8'd4)  begin errors++; $display("FAIL first_draw_x: got %0d want 4", x_coord); end
        if (score !== 8'd0)    begin errors++; $display("FAIL first_draw_score: got %0d want 0", score); end
        if (erase_reqs !== 0)  begin errors++; $display("FAIL first_draw_erase: got %0d erase passes want 0", erase_reqs); end
        repeat (3) do_frame();
        checks += 6;
        if (req_count !== 7)    begin errors++; $display("FAIL frame_req_count: got %0d want 7", req_count); end
        if (erase_reqs !== 3)   begin errors++; $display("FAIL frame_erase_count: got %0d want 3", erase_reqs); end
        if (x_coord !== 8'd7)   begin errors++; $display("FAIL frame_x: got %0d want 7", x_coord); end
        if (score !== 8'd3)     begin errors++; $display("FAIL frame_score: got %0d want 3", score); end
        if (erase !== 1'b0)     begin errors++; $display("FAIL frame_erase_idle: got %b want 0", erase); end
        if (stable_viol !== 0)  begin errors++; $display("FAIL frame_stable: got %0d changes want 0", stable_viol); end
    endtask

    task automatic test_jump();
        int min_y;
        min_y = 127;
        pulse_jump();
        for (int f = 1; f <= 40; f++) begin
            do_frame();
            if (y_coord < min_y) min_y = y_coord;
            if (f == 5) pulse_jump();
            if (f == 1) begin
                checks++;
                if (y_coord !== 7'd99) begin errors++; $display("FAIL jump_f1_y: got %0d want 99", y_coord); end
            end
            if (f == 20) begin
                checks++;
                if (y_coord !== 7'd80) begin errors++; $display("FAIL jump_apex_y: got %0d want 80", y_coord); end
            end
            if (f == 21) begin
                checks++;
                if (y_coord !== 7'd81) begin errors++; $display("FAIL jump_fall_y: got %0d want 81", y_coord); end
            end
        end
        checks += 5;
        if (y_coord !== 7'd100) begin errors++; $display("FAIL jump_land_y: got %0d want 100", y_coord); end
        if (min_y !== 80)       begin errors++; $display("FAIL jump_min_y: got %0d want 80", min_y); end
        if (x_coord !== 8'd47)  begin errors++; $display("FAIL jump_x: got %0d want 47", x_coord); end
        if (score !== 8'd43)    begin errors++; $display("FAIL jump_score: got %0d want 43", score); end
        if (stable_viol !== 0)  begin errors++; $display("FAIL jump_stable: got %0d changes want 0", stable_viol); end
    endtask

    task automatic test_frame_drop();
        int base;
        base = req_count;
        pulse_tick();
        wait_reqs(base + 1);
        repeat (3) pulse_tick();
        wait_reqs(base + 4);
        settle();
        repeat (60) @(negedge clock);
        checks += 3;
        if (req_count !== base + 4) begin errors++; $display("FAIL drop_req_count: got %0d want %0d", req_count, base + 4); end
        if (score !== 8'd45)        begin errors++; $display("FAIL drop_score: got %0d want 45", score); end
        if (x_coord !== 8'd49)      begin errors++; $display("FAIL drop_x: got %0d want 49", x_coord); end
    endtask

    task automatic test_flags_both();
        int base;
        base = req_count;
        pulse_tick();
        wait_reqs(base + 2);
        collided = 1'b1;
        reached_screen_end = 1'b1;
        settle();
        checks += 4;
        if (game_over !== 1'b1) begin errors++; $display("FAIL both_game_over: got %b want 1", game_over); end
        if (win !== 1'b0)       begin errors++; $display("FAIL both_win: got %b want 0", win); end
        if (score !== 8'd46)    begin errors++; $display("FAIL both_score: got %0d want 46", score); end
        if (x_coord !== 8'd50)  begin errors++; $display("FAIL both_x: got %0d want 50", x_coord); end
        repeat (2) pulse_tick();
        pulse_jump();
        repeat (40) @(negedge clock);
        checks += 5;
        if (x_coord !== 8'd50)      begin errors++; $display("FAIL frozen_x: got %0d want 50", x_coord); end
        if (y_coord !== 7'd100)     begin errors++; $display("FAIL frozen_y: got %0d want 100", y_coord); end
        if (score !== 8'd46)        begin errors++; $display("FAIL frozen_score: got %0d want 46", score); end
        if (req_count !== base + 2) begin errors++; $display("FAIL frozen_req: got %0d want %0d", req_count, base + 2); end
        if (game_over !== 1'b1)     begin errors++; $display("FAIL frozen_game_over: got %b want 1", game_over); end
    endtask

    task automatic test_restart_win();
        int base;
        pulse_start();
        checks += 2;
        if (collision_clear_n !== 1'b0) begin errors++; $display("FAIL over_idle_clear_n: got %b want 0", collision_clear_n); end
        if (game_over !== 1'b0)         begin errors++; $display("FAIL over_idle_game_over: got %b want 0", game_over); end
        collided = 1'b0;
        reached_screen_end = 1'b0;
        pulse_start();
        base = req_count;
        wait_reqs(base + 1);
        settle();
        checks += 3;
        if (x_coord !== 8'd4)           begin errors++; $display("FAIL restart_x: got %0d want 4", x_coord); end
        if (score !== 8'd0)             begin errors++; $display("FAIL restart_score: got %0d want 0", score); end
        if (collision_clear_n !== 1'b1) begin errors++; $display("FAIL restart_clear_n: got %b want 1", collision_clear_n); end
        for (int f = 1; f <= 157; f++) begin
            do_frame();
            if (f == 155) begin
                checks++;
                if (x_coord !== 8'd159) begin errors++; $display("FAIL edge_x: got %0d want 159", x_coord); end
            end
        end
        checks += 2;
        if (x_coord !== 8'd159) begin errors++; $display("FAIL sat_x: got %0d want 159", x_coord); end
        if (score !== 8'd157)   begin errors++; $display("FAIL sat_score: got %0d want 157", score); end
        base = req_count;
        pulse_tick();
        wait_reqs(base + 2);
        reached_screen_end = 1'b1;
        settle();
        checks += 3;
        if (win !== 1'b1)       begin errors++; $display("FAIL win_level: got %b want 1", win); end
        if (game_over !== 1'b0) begin errors++; $display("FAIL win_game_over: got %b want 0", game_over); end
        if (score !== 8'd158)   begin errors++; $display("FAIL win_score: got %0d want 158", score); end
        pulse_start();
        checks += 2;
        if (collision_clear_n !== 1'b0) begin errors++; $display("FAIL win_idle_clear_n: got %b want 0", collision_clear_n); end
        if (win !== 1'b0)               begin errors++; $display("FAIL win_idle_win: got %b want 0", win); end
        reached_screen_end = 1'b0;
        pulse_start();
        base = req_count;
        wait_reqs(base + 1);
        settle();
        checks += 3;
        if (x_coord !== 8'd4) begin errors++; $display("FAIL win_restart_x: got %0d want 4", x_coord); end
        if (score !== 8'd0)   begin errors++; $display("FAIL win_restart_score: got %0d want 0", score); end
        if (win !== 1'b0)     begin errors++; $display("FAIL win_restart_win: got %b want 0", win); end
    endtask

    task automatic test_reset_erase();
        int base;
        base = req_count;
        pulse_tick();
        wait_reqs(base + 1);
        repeat (3) @(negedge clock);
        checks++;
        if (erase !== 1'b1) begin errors++; $display("FAIL pass_erase: got %b want 1", erase); end
        resetn = 1'b0;
        #1;
        checks += 7;
        if (x_coord !== 8'd4)           begin errors++; $display("FAIL rst_mid_x: got %0d want 4", x_coord); end
        if (y_coord !== 7'd100)         begin errors++; $display("FAIL rst_mid_y: got %0d want 100", y_coord); end
        if (draw_req !== 1'b0)          begin errors++; $display("FAIL rst_mid_draw_req: got %b want 0", draw_req); end
        if (erase !== 1'b0)             begin errors++; $display("FAIL rst_mid_erase: got %b want 0", erase); end
        if (collision_clear_n !== 1'b0) begin errors++; $display("FAIL rst_mid_clear_n: got %b want 0", collision_clear_n); end
        if (score !== 8'd0)             begin errors++; $display("FAIL rst_mid_score: got %0d want 0", score); end
        if (game_over !== 1'b0 || win !== 1'b0) begin errors++; $display("FAIL rst_mid_flags: got %b%b want 00", game_over, win); end
        repeat (3) @(negedge clock);
        resetn = 1'b1;
        repeat (5) @(negedge clock);
        checks += 2;
        if (req_count !== base + 1)     begin errors++; $display("FAIL rst_no_req: got %0d want %0d", req_count, base + 1); end
        if (collision_clear_n !== 1'b0) begin errors++; $display("FAIL rst_idle_clear_n: got %b want 0", collision_clear_n); end
    endtask

    initial begin
        test_reset();
        test_normal_frame();
        test_jump();
        test_frame_drop();
        test_flags_both();
        test_restart_win();
        test_reset_erase();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/game_sequencer.md
# game_sequencer

Per-frame controller for the side-scrolling sprite game on the 160x120 VGA framebuffer. Each frame it sequences the sprite drawer through erase, move, redraw and collision check, owns the sprite position and jump motion, and reads the sticky `collided` / `reached_screen_end` flags from the collision detector to decide game over or win. It sits between the key/frame-tick front end and the pixel-drawing datapath.

## Interface
- `X_START`, 8'd4: sprite x after start.
- `Y_GROUND`, 7'd100: sprite top y when on the ground.
- `X_STEP`, 8'd1: pixels advanced per frame.
- `JUMP_H`, 7'd20: jump apex height in pixels; rise and fall at 1 px/frame.
- `clock`  in  1: system clock.
- `resetn`  in  1: asynchronous, active-low reset.
- `start`  in  1: one-cycle pulse, already synchronised and edge-detected.
- `jump`  in  1: one-cycle pulse.
- `frame_tick`  in  1: one-cycle pulse per video frame.
- `draw_done`  in  1: one-cycle pulse from the drawer when the requested sprite pass is complete.
- `collided`  in  1: sticky flag from the collision detector.
- `reached_screen_end`  in  1: sticky flag from the collision detector.
- `x_coord`  out  8: sprite x.
- `y_coord`  out  7: sprite y, equal to `Y_GROUND - height`.
- `draw_req`  out  1: one-cycle pulse that starts a drawer pass.
- `erase`  out  1: level. 1 means the drawer writes background colour; valid from the `draw_req` cycle through `draw_done`.
- `collision_clear_n`  out  1: active-low. ANDed into the collision detector's `resetn`.
- `game_over`, `win`  out  1: levels.
- `score`  out  8: frames survived, saturating.

## Operation
- States:
  - IDLE
  - INIT: 1 cycle.
  - DRAW
  - CHECK1
  - CHECK2
  - WAIT_FRAME
  - ERASE
  - MOVE: 1 cycle.
  - GAME_OVER
  - WIN
- IDLE:
  - `collision_clear_n`=0.
  - `start` -> INIT.
- INIT:
  - Loads `x_coord`=X_START, height=0, `score`=0.
  - Clears pending flags.
  - -> DRAW.
- DRAW:
  - `draw_req` pulses on entry with `erase`=0.
  - Waits for `draw_done`, then -> CHECK1.
- CHECK1 -> CHECK2:
  - Gives the collision detector's registered flags time to settle.
- CHECK2 samples the flags:
  - `collided`=1 -> GAME_OVER. This has priority when both flags are set.
  - else `reached_screen_end`=1 -> WIN.
  - else -> WAIT_FRAME.
- WAIT_FRAME: `frame_pend`=1 -> ERASE, clearing `frame_pend`.
- ERASE:
  - `draw_req` pulses with `erase`=1 at the current position.
  - `draw_done` -> MOVE.
- MOVE:
  - `x_coord` += X_STEP, saturating at 159.
  - Height steps per the jump rules below.
  - `score` += 1, saturating at 255.
  - -> DRAW.
- Jump rules:
  - `jump` is accepted only while height=0 and not rising; it sets `jump_pend`. `jump` while airborne is ignored.
  - At MOVE:
    - `jump_pend` -> rising=1, height=1.
    - rising -> height+1, and at JUMP_H clear rising.
    - falling -> height-1, down to 0.
- `frame_tick` in any non-WAIT_FRAME state sets `frame_pend`. Multiple ticks while busy collapse into one, so frames are dropped and not queued.
- `frame_tick` in the same cycle as the WAIT_FRAME consume keeps `frame_pend` clear. The tick is consumed by that transition.
- GAME_OVER / WIN:
  - Hold `x_coord`, `y_coord` and `score`.
  - `start` -> IDLE, which clears the collision detector; a second `start` begins play.
- `start` in any other state is ignored.
- `draw_done` outside DRAW/ERASE is ignored.

## Timing
- Reset values (asynchronous):
  - State = IDLE.
  - `x_coord`=X_START, `y_coord`=Y_GROUND.
  - `draw_req`=0, `erase`=0, `collision_clear_n`=0, `game_over`=0, `win`=0, `score`=0.
  - Pending flags = 0.
- All outputs are registered.
- `draw_req` is high exactly 1 cycle, the first cycle of DRAW/ERASE.
- `x_coord`, `y_coord` and `erase` are stable from `draw_req` until `draw_done`.
- Minimum frame cycle, with the drawer taking D cycles per pass, is 2D + 6 cycles.
- `game_over`/`win` rise the cycle after CHECK2 samples.
- `collision_clear_n` is low every cycle in IDLE and high in all other states.
- Reset mid-pass abandons the drawer handshake. The drawer shares `resetn` and is reset with this block.

## Structure
- Shared package `game_pkg` holds:
  - SCREEN_W=160, SCREEN_H=120.
  - X_END=154.
  - Colour codes: BG, OBSTACLE=3'b010, SPRITE.
  - The state enum.
- Sub-module `sprite_motion` holds the x/height registers, jump pending/rising logic and saturation, with a `step` strobe driven in MOVE.
- The top level holds the FSM, the pending flags and the score.

## Test plan
- Normal frame: reset, `start`, D=10 drawer, 3 `frame_tick` with no collision -> 3 ERASE/DRAW pairs; `x_coord`=7, `score`=3, `draw_req` pulses exactly 7 times (1 initial draw + 2 per frame).
- Jump: `jump` then JUMP_H+JUMP_H frames -> `y_coord` falls to 80 then returns to 100. A second `jump` at height 5 is ignored.
- Simultaneous flags: force `collided`=1 and `reached_screen_end`=1 before CHECK2 -> `game_over`=1, `win`=0, outputs frozen.
- Frame drop: 3 `frame_tick`s during one ERASE pass -> exactly one extra frame processed, `score` +2 in total (current frame + one pending).
- Restart and win: in WIN, `start` -> `collision_clear_n` low for ≥1 cycle; `start` -> `x_coord`=4, `score`=0. Holding `reached_screen_end`=1 in CHECK2 -> `win`=1.
- Reset during ERASE: assert `resetn`=0 mid-pass -> all outputs at reset values in the same cycle, with no `draw_req`.
